// File: rtl/register_file.sv
// MIPS architectural register file: two combinational read ports, one write
// port, hardwired-zero r0, and a valid/ready debug dump engine.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  dump_req,
  input  logic                  dump_ready,
  output logic                  dump_valid,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_busy,
  output logic                  dump_done
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] idx_r, idx_s;
  logic                  done_r, done_s;

  // Register array; r0 is never written so it stays zero after reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (reg_write && (write_addr != '0)) begin
      regs_r[write_addr] <= write_data;
    end
  end

  // Read ports: no write bypass, r0 forced to zero.
  always_comb begin
    read_data_a = '0;
    read_data_b = '0;
    if (read_addr_a != '0) begin
      read_data_a = regs_r[read_addr_a];
    end else begin
      read_data_a = '0;
    end
    if (read_addr_b != '0) begin
      read_data_b = regs_r[read_addr_b];
    end else begin
      read_data_b = '0;
    end
  end

  // Dump FSM state, beat index and completion pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
      idx_r   <= '0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      done_r  <= done_s;
    end
  end

  // Dump next-state logic; dump_req is only honoured from IDLE.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (dump_req) begin
          state_s = RUN;
          idx_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (dump_ready) begin
          if (idx_r == LAST_IDX) begin
            state_s = IDLE;
            idx_s   = '0;
            done_s  = 1'b1;
          end else begin
            idx_s = idx_r + IDX_ONE;
          end
        end else begin
          idx_s = idx_r;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = '0;
      end
    endcase
  end

  // Beat outputs track current register contents while running.
  always_comb begin
    dump_valid = 1'b0;
    dump_busy  = 1'b0;
    dump_addr  = '0;
    dump_data  = '0;
    if (state_r == RUN) begin
      dump_valid = 1'b1;
      dump_busy  = 1'b1;
      dump_addr  = idx_r;
      dump_data  = regs_r[idx_r];
    end else begin
      dump_valid = 1'b0;
      dump_busy  = 1'b0;
    end
  end

  assign dump_done = done_r;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a read/write vector table followed by
// hand-written dump sequences (full dump, stall, restart, reset mid-dump).
module tb_register_file;

  logic        CLK;
  logic        RST_N;
  logic [4:0]  read_addr_a, read_addr_b, write_addr, dump_addr;
  logic [31:0] read_data_a, read_data_b, write_data, dump_data;
  logic        reg_write, dump_req, dump_ready, dump_valid, dump_busy, dump_done;

  int n_checks = 0;
  int n_fails  = 0;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
    .read_data_a(read_data_a), .read_data_b(read_data_b),
    .reg_write(reg_write), .write_addr(write_addr), .write_data(write_data),
    .dump_req(dump_req), .dump_ready(dump_ready), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_busy(dump_busy),
    .dump_done(dump_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rw;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 5'd0,  32'h0000_0000, 5'd5,  5'd31, 32'h0000_0000, 32'h0000_0000};
    vecs[1] = '{1'b1, 5'd8,  32'hFFFF_1111, 5'd8,  5'd0,  32'hFFFF_1111, 32'h0000_0000};
    vecs[2] = '{1'b0, 5'd8,  32'h0000_0001, 5'd8,  5'd8,  32'hFFFF_1111, 32'hFFFF_1111};
    vecs[3] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{1'b1, 5'd31, 32'hA5A5_5A5A, 5'd31, 5'd8,  32'hA5A5_5A5A, 32'hFFFF_1111};
    vecs[5] = '{1'b1, 5'd1,  32'h1234_5678, 5'd1,  5'd31, 32'h1234_5678, 32'hA5A5_5A5A};
    vecs[6] = '{1'b1, 5'd8,  32'h0000_0002, 5'd8,  5'd1,  32'h0000_0002, 32'h1234_5678};

    RST_N = 1'b0; reg_write = 1'b0; write_addr = 5'd0; write_data = 32'h0;
    read_addr_a = 5'd5; read_addr_b = 5'd31; dump_req = 1'b0; dump_ready = 1'b0;
    #12;
    RST_N = 1'b1;
    #1;
    check("reset read_a", read_data_a, 32'h0);
    check("reset read_b", read_data_b, 32'h0);
    check("reset dump_valid", {31'h0, dump_valid}, 32'h0);
    check("reset dump_busy", {31'h0, dump_busy}, 32'h0);
    check("reset dump_done", {31'h0, dump_done}, 32'h0);

    for (int i = 0; i < 7; i++) begin
      reg_write = vecs[i].rw; write_addr = vecs[i].wa; write_data = vecs[i].wd;
      tick();
      reg_write = 1'b0;
      read_addr_a = vecs[i].ra; read_addr_b = vecs[i].rb;
      #1;
      check($sformatf("vec%0d read_a", i), read_data_a, vecs[i].ea);
      check($sformatf("vec%0d read_b", i), read_data_b, vecs[i].eb);
    end

    // No bypass: reading the write target before the edge sees the old value
    reg_write = 1'b1; write_addr = 5'd3; write_data = 32'hCAFE_0003; read_addr_a = 5'd3;
    #1;
    check("no bypass before edge", read_data_a, 32'h0);
    tick();
    reg_write = 1'b0;
    #1;
    check("write visible after edge", read_data_a, 32'hCAFE_0003);

    // Preload reg[k] = k * 0x0001_0001
    for (int k = 0; k < 32; k++) begin
      reg_write = 1'b1; write_addr = 5'(k); write_data = 32'(k) * 32'h0001_0001;
      tick();
    end
    reg_write = 1'b0;

    dump_req = 1'b1; dump_ready = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int k = 0; k < 32; k++) begin
      check($sformatf("beat%0d valid", k), {31'h0, dump_valid}, 32'h1);
      check($sformatf("beat%0d addr", k), {27'h0, dump_addr}, 32'(k));
      check($sformatf("beat%0d data", k), dump_data, 32'(k) * 32'h0001_0001);
      check($sformatf("beat%0d done low", k), {31'h0, dump_done}, 32'h0);
      tick();
    end
    check("dump_done pulse", {31'h0, dump_done}, 32'h1);
    check("busy after dump", {31'h0, dump_busy}, 32'h0);
    check("valid after dump", {31'h0, dump_valid}, 32'h0);

    // Restart requested in the dump_done cycle
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    check("restart valid", {31'h0, dump_valid}, 32'h1);
    check("restart addr", {27'h0, dump_addr}, 32'h0);
    check("done single cycle", {31'h0, dump_done}, 32'h0);
    repeat (10) tick();
    check("reach idx10", {27'h0, dump_addr}, 32'd10);

    // Stall at idx 10 with a mid-dump request that must be ignored
    dump_ready = 1'b0; dump_req = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      check($sformatf("stall%0d addr", s), {27'h0, dump_addr}, 32'd10);
      check($sformatf("stall%0d valid", s), {31'h0, dump_valid}, 32'h1);
      check($sformatf("stall%0d data", s), dump_data, 32'h000A_000A);
    end
    dump_req = 1'b0; dump_ready = 1'b1;
    reg_write = 1'b1; write_addr = 5'd10; write_data = 32'hF001_0001;
    #1;
    check("accept beat old value", dump_data, 32'h000A_000A);
    tick();
    reg_write = 1'b0;
    check("advance past stall", {27'h0, dump_addr}, 32'd11);
    read_addr_a = 5'd10;
    #1;
    check("write during dump lands", read_data_a, 32'hF001_0001);

    // dump_data follows a write to the held index
    dump_ready = 1'b0;
    reg_write = 1'b1; write_addr = 5'd11; write_data = 32'h1234_ABCD;
    tick();
    reg_write = 1'b0;
    check("held addr 11", {27'h0, dump_addr}, 32'd11);
    check("held data follows write", dump_data, 32'h1234_ABCD);

    dump_ready = 1'b1;
    repeat (9) tick();
    check("reach idx20", {27'h0, dump_addr}, 32'd20);

    // Asynchronous reset mid-dump
    #2;
    RST_N = 1'b0;
    #1;
    check("rst busy drops", {31'h0, dump_busy}, 32'h0);
    check("rst valid drops", {31'h0, dump_valid}, 32'h0);
    check("rst no done", {31'h0, dump_done}, 32'h0);
    tick();
    RST_N = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("post-rst done%0d", c), {31'h0, dump_done}, 32'h0);
      check($sformatf("post-rst busy%0d", c), {31'h0, dump_busy}, 32'h0);
    end
    read_addr_a = 5'd10; read_addr_b = 5'd31;
    #1;
    check("post-rst read r10", read_data_a, 32'h0);
    check("post-rst read r31", read_data_b, 32'h0);
    read_addr_a = 5'd8; read_addr_b = 5'd11;
    #1;
    check("post-rst read r8", read_data_a, 32'h0);
    check("post-rst read r11", read_data_b, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
